// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a debounce FSM that yields a clean level
// plus one-cycle press/release pulses. Define BUTTON_DEBOUNCER_LONG_PRESS_EN to add btn_long.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned LONG_PRESS_CYCLES = 25000000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic clk_25,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);
    localparam int unsigned CNT_W     = 26;
    localparam int unsigned CNT_LIMIT = 32'd1 << CNT_W;
    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RELEASED_PIN = ACTIVE_LOW;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= CNT_LIMIT ||
        LONG_PRESS_CYCLES < 1 || LONG_PRESS_CYCLES >= CNT_LIMIT) begin : g_param_check
        $error("button_debouncer: cycle count parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [1:0]       sync_reg;
    logic             pressed_sync;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             btn_level_reg;
    logic             btn_press_reg;
    logic             btn_release_reg;
    logic             accept_press;
    logic             accept_release;

    // Both stages reset to the idle pin level so reset never looks like a press edge.
    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            sync_reg <= {2{RELEASED_PIN}};
        end else begin
            sync_reg <= {sync_reg[0], btn_in};
        end
    end

    assign pressed_sync   = sync_reg[1] ^ ACTIVE_LOW;
    assign accept_press   = (state_reg == PRESS_WAIT) && pressed_sync && (cnt_reg == DEB_LAST);
    assign accept_release = (state_reg == RELEASE_WAIT) && !pressed_sync && (cnt_reg == DEB_LAST);

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            btn_level_reg   <= 1'b0;
            btn_press_reg   <= 1'b0;
            btn_release_reg <= 1'b0;
        end else begin
            btn_press_reg   <= 1'b0;
            btn_release_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pressed_sync) begin
                        state_reg <= PRESS_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_sync) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (accept_press) begin
                        state_reg     <= PRESSED;
                        btn_level_reg <= 1'b1;
                        btn_press_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!pressed_sync) begin
                        state_reg <= RELEASE_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A pressed sample here is contact bounce: fall back without a pulse.
                    if (pressed_sync) begin
                        state_reg <= PRESSED;
                    end else if (accept_release) begin
                        state_reg       <= IDLE;
                        btn_level_reg   <= 1'b0;
                        btn_release_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign btn_level   = btn_level_reg;
    assign btn_press   = btn_press_reg;
    assign btn_release = btn_release_reg;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYCLES);

    logic [CNT_W-1:0] hold_reg;
    logic             btn_long_reg;
    logic             holding;

    assign holding = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);

    // hold parks one past the firing value so btn_long fires once per press.
    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            hold_reg     <= '0;
            btn_long_reg <= 1'b0;
        end else begin
            btn_long_reg <= holding && (hold_reg == LONG_LAST);
            if (!holding || accept_release) begin
                hold_reg <= '0;
            end else if (hold_reg != LONG_SAT) begin
                hold_reg <= hold_reg + 1'b1;
            end
        end
    end

    assign btn_long = btn_long_reg;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Input-side counterpart to the board's LED driver logic. Samples one raw, bouncing, asynchronous push-button in the 25 MHz domain and produces a clean debounced level plus single-cycle press and release pulses. An optional long-press pulse can be compiled in. Sits between a board push-button pin and any control logic, such as mode select or blink-rate select.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a change (10 ms at 25 MHz); legal range 1 .. 2^26-1.
- LONG_PRESS_CYCLES, 25000000: held cycles in debounced-pressed state before btn_long fires (1 s); legal range 1 .. 2^26-1.
- ACTIVE_LOW, 1: 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- clk_25  input  1  system clock, 25 MHz; the only clock.
- reset_n  input  1  synchronous, active-low reset.
- btn_in  input  1  raw button pin; asynchronous; may bounce.
- btn_level  output  1  debounced state, 1 = pressed.
- btn_press  output  1  one-cycle pulse on accepted press.
- btn_release  output  1  one-cycle pulse on accepted release.
- btn_long  output  1  one-cycle pulse on long press; constant 0 without the macro.

## Operation
- Synchronizer: two flops on btn_in, then polarity normalisation (pressed = 1). On reset both flops load the released pin level (ACTIVE_LOW ? 1 : 0).
- Counters: one 26-bit debounce counter `cnt`; one 26-bit hold counter `hold` (macro only).
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; reset state is IDLE.
- IDLE: synced pressed -> PRESS_WAIT, cnt <= 0.
- PRESS_WAIT:
  - synced released -> IDLE, cnt <= 0, no pulse.
  - pressed and cnt == DEBOUNCE_CYCLES-1 -> PRESSED; btn_press registered high for the next cycle.
  - otherwise cnt++.
- PRESSED: synced released -> RELEASE_WAIT, cnt <= 0.
- RELEASE_WAIT:
  - synced pressed -> PRESSED, no pulse (bounce).
  - released and cnt == DEBOUNCE_CYCLES-1 -> IDLE; btn_release registered high for the next cycle.
  - otherwise cnt++.
- btn_level = 1 in PRESSED and RELEASE_WAIT, 0 otherwise. It is registered, so it changes on the same edge as the corresponding pulse.
- All outputs are registered; no combinational path from btn_in.

## Timing
- Reset values: state IDLE, cnt 0, hold 0, btn_level 0, btn_press 0, btn_release 0, btn_long 0.
- Reset is synchronous and overrides everything on that edge. Reset mid-debounce or mid-press discards progress and emits no pulse.
- Button held through reset deassertion: treated as a fresh press; btn_press fires after the normal latency.
- Press latency: btn_in pressed and stable, first sampled at edge 0 -> btn_level and btn_press high after edge DEBOUNCE_CYCLES+2. btn_press falls one edge later.
- Release latency: identical, DEBOUNCE_CYCLES+2 edges.
- Bounce inside the window restarts the debounce in both directions; a glitch shorter than DEBOUNCE_CYCLES produces no output change.
- Pulses: each btn_press / btn_release / btn_long pulse is exactly one cycle. btn_press and btn_release can never be high together. Minimum spacing between them is DEBOUNCE_CYCLES+1 cycles.

## Configuration
- Macro: BUTTON_DEBOUNCER_LONG_PRESS_EN.
- Defined:
  - hold clears on entry to PRESSED from PRESS_WAIT and counts every cycle in PRESSED and RELEASE_WAIT.
  - When hold == LONG_PRESS_CYCLES-1, btn_long pulses once; hold then saturates and no further btn_long fires for that press.
  - hold clears on entry to IDLE.
- Not defined: hold counter absent; btn_long tied to 0; all other behaviour identical.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1.
- Clean press: btn_in 1->0, first sampled at edge 0, held -> btn_level=1 and btn_press=1 after edge 6; btn_press=0 after edge 7; btn_release never asserts.
- Bounce rejection: btn_in low 3 cycles, high 1, low 3, high -> btn_level stays 0; no pulses.
- Clean release after a clean press: btn_in 0->1 held -> btn_release single pulse and btn_level=0 after 6 edges; release bounce of 2 cycles low restarts the window with no extra pulses.
- Long press, macro defined: hold low 20 cycles -> btn_long exactly one pulse, 10 cycles after btn_press; none thereafter. Macro undefined -> btn_long constant 0.
- Reset mid-press: assert reset_n=0 during PRESS_WAIT (cnt=2) -> all outputs 0, state IDLE. Deassert with btn_in still low -> btn_press after edge 6 counted from the first post-reset edge.
- Polarity: ACTIVE_LOW=0, btn_in 0->1 held -> btn_press after edge 6; idle-low input produces no pulses after reset.
